// File: rtl/klc_pkg.sv
// klc_pkg: shared state encoding and default timing constants for kernel_launch_ctrl.
package klc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CRST = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } klcState_e;

    localparam int          KLC_CORE_RST_CYC = 2;
    localparam logic [15:0] KLC_WDOG_LIMIT   = 16'hFFFF;

    // Width needed to hold (cyc - 1) in the core-reset down-counter.
    function automatic int rstCntWidth(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/kernel_launch_ctrl_if.sv
// kernel_launch_ctrl_if: host loader word-transfer handshake into the launch controller.
interface kernel_launch_ctrl_if #(
    parameter int IMEM_AW = 6,
    parameter int DATA_W  = 32
);
    logic               ld_valid;
    logic               ld_ready;
    logic               ld_last;
    logic [IMEM_AW-1:0] ld_addr;
    logic [DATA_W-1:0]  ld_data;

    modport master (output ld_valid, ld_last, ld_addr, ld_data, input ld_ready);
    modport slave  (input ld_valid, ld_last, ld_addr, ld_data, output ld_ready);
endinterface

// File: rtl/klc_cycle_counter.sv
// klc_cycle_counter: saturating up-counter with synchronous clear and an at-limit compare,
// shared by the RUN cycle count and the watchdog.
module klc_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             atLimit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign atLimit = (count == limit);

endmodule

// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl: sequences one RISC-V kernel launch (load imem, reset core, run, report).
// Optional watchdog on RUN length enabled by defining KLC_WATCHDOG_EN.
//
// state | meaning
// IDLE  | core held in reset, waiting for host_start
// LOAD  | loader owns imem port, accepts words until ld_last
// CRST  | core reset held for CORE_RST_CYC cycles
// RUN   | core running, cycle count advancing, waiting for done
// DONE  | one-cycle host_done pulse, core back in reset
module kernel_launch_ctrl
    import klc_pkg::*;
#(
    parameter int               IMEM_AW      = 6,
    parameter int               DATA_W       = 32,
    parameter int               CORE_RST_CYC = KLC_CORE_RST_CYC,
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] WDOG_LIMIT   = CNT_W'(KLC_WDOG_LIMIT)
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,

    input  logic               host_start,
    output logic               host_idle,
    output logic               host_done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,

    kernel_launch_ctrl_if.slave ld,

    output logic               core_rst,
    output logic               core_start,
    input  logic               core_done,
    input  logic [IMEM_AW-1:0] core_imem_address0,
    output logic [DATA_W-1:0]  core_imem_q0,

    output logic [IMEM_AW-1:0] imem_address0,
    output logic               imem_ce0,
    output logic               imem_we0,
    output logic [DATA_W-1:0]  imem_d0,
    input  logic [DATA_W-1:0]  imem_q0
);

    localparam int RST_W = rstCntWidth(CORE_RST_CYC);

    klcState_e        state;
    logic [RST_W-1:0] rstCnt;
    logic             ldReady;
    logic             doneReg;
    logic             timeoutReg;
    logic             xfer;
    logic             wdogHit;
    logic             goDone;
    logic             cntClr;
    logic             cntEn;
    logic             atLimit;

    assign ld.ld_ready = ldReady;
    assign timeout     = timeoutReg;

    // ldReady is only ever high in LOAD, so it doubles as the state qualifier.
    assign xfer = ldReady & ld.ld_valid;

`ifdef KLC_WATCHDOG_EN
    assign wdogHit = atLimit;
`else
    logic unusedAtLimit;
    assign unusedAtLimit = atLimit;
    assign wdogHit       = 1'b0;
`endif

    assign goDone = (state == ST_RUN) && (doneReg || wdogHit);
    assign cntClr = (state == ST_IDLE) && host_start;
    assign cntEn  = (state == ST_RUN) && !goDone;

    klc_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .clr     (cntClr),
        .en      (cntEn),
        .limit   (WDOG_LIMIT),
        .count   (cycle_count),
        .atLimit (atLimit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= ST_IDLE;
            rstCnt     <= '0;
            ldReady    <= 1'b0;
            doneReg    <= 1'b0;
            timeoutReg <= 1'b0;
            host_idle  <= 1'b1;
            host_done  <= 1'b0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
        end else begin
            host_done  <= 1'b0;
            core_start <= 1'b0;
            // The core PC is still at its reset value in the first RUN cycle, so done is masked there.
            doneReg    <= (state == ST_RUN) && !core_start && core_done;

            case (state)
                ST_IDLE: begin
                    core_rst  <= 1'b1;
                    host_idle <= 1'b1;
                    if (host_start) begin
                        state      <= ST_LOAD;
                        host_idle  <= 1'b0;
                        ldReady    <= 1'b1;
                        timeoutReg <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (xfer && ld.ld_last) begin
                        state   <= ST_CRST;
                        ldReady <= 1'b0;
                        rstCnt  <= RST_W'(CORE_RST_CYC - 1);
                    end
                end

                ST_CRST: begin
                    if (rstCnt == '0) begin
                        state      <= ST_RUN;
                        core_rst   <= 1'b0;
                        core_start <= 1'b1;
                    end else begin
                        rstCnt <= rstCnt - 1'b1;
                    end
                end

                ST_RUN: begin
                    if (goDone) begin
                        state     <= ST_DONE;
                        core_rst  <= 1'b1;
                        host_done <= 1'b1;
`ifdef KLC_WATCHDOG_EN
                        // A registered done in the same cycle as expiry wins.
                        timeoutReg <= !doneReg;
`endif
                    end
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    host_idle <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    ldReady   <= 1'b0;
                    host_idle <= 1'b1;
                    core_rst  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        imem_ce0      = 1'b1;
        imem_we0      = 1'b0;
        imem_address0 = core_imem_address0;
        imem_d0       = '0;
        if (state == ST_LOAD) begin
            imem_we0      = xfer;
            imem_address0 = ld.ld_addr;
            imem_d0       = ld.ld_data;
        end
    end

    // Core is held in reset during LOAD, so passing loader-cycle read data through is harmless.
    assign core_imem_q0 = imem_q0;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// tb_kernel_launch_ctrl: randomized launches checked against a cycle-budget model of the launch sequence.
module tb_kernel_launch_ctrl;

    localparam int IMEM_AW      = 6;
    localparam int DATA_W       = 32;
    localparam int CORE_RST_CYC = 2;
    localparam int CNT_W        = 16;
    localparam int WDOG         = 100;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b1;
    logic               host_start = 1'b0;
    logic               host_idle;
    logic               host_done;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_count;
    logic               core_rst;
    logic               core_start;
    logic               core_done = 1'b0;
    logic [IMEM_AW-1:0] core_imem_address0 = '0;
    logic [DATA_W-1:0]  core_imem_q0;
    logic [IMEM_AW-1:0] imem_address0;
    logic               imem_ce0;
    logic               imem_we0;
    logic [DATA_W-1:0]  imem_d0;
    logic [DATA_W-1:0]  imem_q0;

    kernel_launch_ctrl_if #(.IMEM_AW(IMEM_AW), .DATA_W(DATA_W)) ldIf ();

    kernel_launch_ctrl #(
        .IMEM_AW      (IMEM_AW),
        .DATA_W       (DATA_W),
        .CORE_RST_CYC (CORE_RST_CYC),
        .CNT_W        (CNT_W),
        .WDOG_LIMIT   (16'(WDOG))
    ) dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .host_start         (host_start),
        .host_idle          (host_idle),
        .host_done          (host_done),
        .timeout            (timeout),
        .cycle_count        (cycle_count),
        .ld                 (ldIf),
        .core_rst           (core_rst),
        .core_start         (core_start),
        .core_done          (core_done),
        .core_imem_address0 (core_imem_address0),
        .core_imem_q0       (core_imem_q0),
        .imem_address0      (imem_address0),
        .imem_ce0           (imem_ce0),
        .imem_we0           (imem_we0),
        .imem_d0            (imem_d0),
        .imem_q0            (imem_q0)
    );

    always #5 ap_clk = ~ap_clk;

    // Physical imem sitting next to the controller.
    logic [DATA_W-1:0] physMem [2**IMEM_AW];
    assign imem_q0 = physMem[imem_address0];
    int wrCount = 0;
    always @(posedge ap_clk) begin
        if (imem_we0) begin
            physMem[imem_address0] <= imem_d0;
            wrCount <= wrCount + 1;
        end
    end

    logic [DATA_W-1:0]  refMem [2**IMEM_AW];
    bit                 wrote  [2**IMEM_AW];
    logic [IMEM_AW-1:0] written [$];

    int checkCnt = 0;
    int errorCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errorCnt++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // gapSel: 0 no gaps, 1 valid pattern 1,0,0,1, 2 random gaps.
    // doneAt: RUN cycle (0 = core_start cycle) from which core_done is held high; -1 never.
    // abortAt: RUN cycle at which reset is pulsed; -1 none.
    task automatic launch(input int nWords, input bit fixedProg, input int gapSel,
                          input int doneAt, input int abortAt);
        int t, gap, eff, expT, expCnt, rstSeen, wrBase;
        bit wd, expTo;
        logic [IMEM_AW-1:0] a;
        logic [DATA_W-1:0]  d;
`ifdef KLC_WATCHDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        checkVal("idleBeforeStart", host_idle, 1);
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        checkVal("loadReady", ldIf.ld_ready, 1);
        checkVal("startClrCount", cycle_count, 0);
        checkVal("startClrTimeout", timeout, 0);
        wrBase = wrCount;

        for (int i = 0; i < nWords; i++) begin
            gap = (gapSel == 1) ? ((i == 1) ? 2 : 0) :
                  (gapSel == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gap; g++) begin
                ldIf.ld_valid = 1'b0;
                host_start = 1'($urandom_range(0, 1));
                #1;
                checkVal("gapNoWrite", imem_we0, 0);
                tick();
                checkVal("gapStillLoad", ldIf.ld_ready, 1);
            end
            host_start = 1'b0;
            a = fixedProg ? IMEM_AW'(i) : IMEM_AW'($urandom);
            d = (fixedProg && i < nWords - 1) ? 32'h0000_0013 : $urandom;
            ldIf.ld_valid = 1'b1;
            ldIf.ld_addr  = a;
            ldIf.ld_data  = d;
            ldIf.ld_last  = (i == nWords - 1);
            #1;
            checkVal("wrEn", imem_we0, 1);
            checkVal("wrAddr", imem_address0, a);
            checkVal("wrData", imem_d0, d);
            refMem[a] = d;
            if (!wrote[a]) begin
                wrote[a] = 1'b1;
                written.push_back(a);
            end
            tick();
            if (i < nWords - 1) checkVal("noEarlyCrst", ldIf.ld_ready, 1);
        end
        ldIf.ld_valid = 1'b0;
        ldIf.ld_last  = 1'b0;
        checkVal("writeCount", wrCount - wrBase, nWords);

        rstSeen = 0;
        while (!core_start && rstSeen < 20) begin
            checkVal("crstRstHigh", core_rst, 1);
            rstSeen++;
            tick();
        end
        checkVal("crstCycles", rstSeen, CORE_RST_CYC);
        checkVal("runRstLow", core_rst, 0);

        // Done seen in cycle eff sets host_done two cycles later; count stops at eff+1 or the limit.
        eff    = (doneAt < 0) ? (1 << 30) : ((doneAt < 1) ? 1 : doneAt);
        expTo  = wd && (eff + 1 > WDOG);
        expT   = expTo ? WDOG + 1 : eff + 2;
        expCnt = expTo ? WDOG : eff + 1;

        t = 0;
        while (!host_done && t <= expT + 4) begin
            if (t == abortAt) break;
            core_done  = (doneAt >= 0) && (t >= doneAt);
            host_start = 1'($urandom_range(0, 1));
            a = written[$urandom_range(0, written.size() - 1)];
            core_imem_address0 = a;
            #1;
            checkVal("fetchAddr", imem_address0, a);
            checkVal("fetchData", core_imem_q0, refMem[a]);
            tick();
            t++;
            if (t == 1) checkVal("startOnePulse", core_start, 0);
            if (t == 10 && expT > 12) checkVal("midCount", cycle_count, 10);
        end

        if (abortAt >= 0 && t == abortAt) begin
            ap_rst_n = 1'b0;
            #1;
            checkVal("abortCoreRst", core_rst, 1);
            checkVal("abortHostDone", host_done, 0);
            checkVal("abortIdle", host_idle, 1);
            checkVal("abortLdReady", ldIf.ld_ready, 0);
            checkVal("abortCount", cycle_count, 0);
            checkVal("abortStart", core_start, 0);
            core_done  = 1'b0;
            host_start = 1'b0;
            tick();
            tick();
            ap_rst_n = 1'b1;
            tick();
            return;
        end

        checkVal("doneTime", t, expT);
        checkVal("cycleCount", cycle_count, expCnt);
        checkVal("timeoutFlag", timeout, expTo);
        checkVal("doneCoreRst", core_rst, 1);
        core_done  = 1'b0;
        host_start = 1'b1;
        tick();
        checkVal("doneOnePulse", host_done, 0);
        checkVal("backIdle", host_idle, 1);
        host_start = 1'b0;
        tick();
        checkVal("startDropped", host_idle, 1);
        checkVal("countHolds", cycle_count, expCnt);
        checkVal("timeoutHolds", timeout, expTo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL globalTimeout at %0t", $time);
        $fatal(1, "simulation time budget exhausted");
    end

    initial begin
        ldIf.ld_valid = 1'b0;
        ldIf.ld_last  = 1'b0;
        ldIf.ld_addr  = '0;
        ldIf.ld_data  = '0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkVal("rstCoreRst", core_rst, 1);
        checkVal("rstIdle", host_idle, 1);
        checkVal("rstHostDone", host_done, 0);
        checkVal("rstCoreStart", core_start, 0);
        checkVal("rstLdReady", ldIf.ld_ready, 0);
        checkVal("rstTimeout", timeout, 0);
        checkVal("rstCount", cycle_count, 0);
        checkVal("rstWe", imem_we0, 0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        repeat (5) tick();
        checkVal("idleHolds", host_idle, 1);
        checkVal("idleNoReady", ldIf.ld_ready, 0);

        launch(4, 1'b1, 0, 50, -1);
        launch(2, 1'b0, 1, int'($urandom_range(1, 40)), -1);
        launch(3, 1'b0, 2, 0, -1);
`ifdef KLC_WATCHDOG_EN
        launch(2, 1'b0, 2, -1, -1);
        launch(2, 1'b0, 0, WDOG - 1, -1);
        launch(2, 1'b0, 0, WDOG, -1);
`else
        launch(2, 1'b0, 2, 150, -1);
`endif
        launch(3, 1'b0, 2, -1, 20);
        launch(4, 1'b0, 2, 30, -1);
        repeat (6) launch(int'($urandom_range(1, 8)), 1'b0, 2, int'($urandom_range(0, 60)), -1);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
        $finish;
    end

endmodule
